// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters with optional forced re-arbitration after
// MAX_HOLD enabled cycles; the last granted index has the lowest priority next time.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0,
  localparam int W       = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [N-1:0] req,
  input  logic         release_grant,
  output logic [W-1:0] grant,
  output logic         grant_valid,
  output logic [N-1:0] grant_onehot
);

  localparam int HW        = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_nxt;
  logic [W-1:0]   grant_nxt;
  logic [W-1:0]   cand;
  logic [W-1:0]   idx;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_nxt;
  logic           any_req;
  logic           hold_hit;
  logic           end_tenure;

  // Scan from ptr+N down to ptr+1 so the nearest requester after ptr wins.
  always_comb begin
    cand = ptr;
    idx  = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) cand = idx;
    end
  end

  assign any_req    = |req;
  assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HW'(HOLD_LAST));
  assign end_tenure = ce && (release_grant || hold_hit);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    if (ce) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state_nxt = BUSY;
            grant_nxt = cand;
            ptr_nxt   = cand;
            hold_nxt  = '0;
          end
        end
        BUSY: begin
          if (end_tenure) begin
            if (any_req) begin
              grant_nxt = cand;
              ptr_nxt   = cand;
              hold_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else if (MAX_HOLD != 0) begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ptr resets to N-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= W'(N - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign grant_valid = (state == BUSY);

  always_comb begin
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: a 4-requester instance with hold limit 4 and a 3-requester
// instance with no hold limit, both compared every cycle against a tenure-level model.
module tb_rr_arbiter_n;

  typedef struct {
    bit valid;
    int grant;
    int ptr;
    int age;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_n_a, ce_a, rel_a;
  logic [3:0] req_a;
  logic [1:0] grant_a;
  logic       valid_a;
  logic [3:0] onehot_a;

  logic       rst_n_b, ce_b, rel_b;
  logic [2:0] req_b;
  logic [1:0] grant_b;
  logic       valid_b;
  logic [2:0] onehot_b;

  int     vectors     = 0;
  int     miscompares = 0;
  model_t ma, mb;

  always #5 clk = ~clk;

  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .ce(ce_a), .req(req_a), .release_grant(rel_a),
    .grant(grant_a), .grant_valid(valid_a), .grant_onehot(onehot_a)
  );

  rr_arbiter_n #(.N(3), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .ce(ce_b), .req(req_b), .release_grant(rel_b),
    .grant(grant_b), .grant_valid(valid_b), .grant_onehot(onehot_b)
  );

  function automatic model_t modelReset(int n);
    model_t m;
    m.valid = 1'b0;
    m.grant = 0;
    m.ptr   = n - 1;
    m.age   = 0;
    return m;
  endfunction

  // One enabled cycle of the arbiter described as tenures: who is next after ptr,
  // and whether the current tenure ends by release or by having lasted mh cycles.
  function automatic model_t modelStep(model_t m, int n, int mh, bit ce, logic [15:0] rq, bit rel);
    model_t r = m;
    int     pick = -1;
    bit     done;
    if (!ce) return r;
    for (int k = 1; k <= n; k++)
      if (pick < 0 && rq[(m.ptr + k) % n]) pick = (m.ptr + k) % n;
    done = m.valid && (rel || (mh != 0 && m.age + 1 == mh));
    if (!m.valid || done) begin
      if (pick >= 0) begin
        r.valid = 1'b1;
        r.grant = pick;
        r.ptr   = pick;
        r.age   = 0;
      end else begin
        r.valid = 1'b0;
      end
    end else begin
      r.age = m.age + 1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("a_valid",  32'(valid_a),  32'(ma.valid));
    check("a_grant",  32'(grant_a),  32'(ma.grant));
    check("a_onehot", 32'(onehot_a), ma.valid ? (32'd1 << ma.grant) : 32'd0);
    check("b_valid",  32'(valid_b),  32'(mb.valid));
    check("b_grant",  32'(grant_b),  32'(mb.grant));
    check("b_onehot", 32'(onehot_b), mb.valid ? (32'd1 << mb.grant) : 32'd0);
  endtask

  // Called just after a rising edge: drive, clock once, advance model, compare.
  task automatic applyStimulus(input bit cea, input logic [3:0] rqa, input bit rla,
                               input bit ceb, input logic [2:0] rqb, input bit rlb);
    ce_a  = cea;
    req_a = rqa;
    rel_a = rla;
    ce_b  = ceb;
    req_b = rqb;
    rel_b = rlb;
    @(posedge clk);
    if (rst_n_a) ma = modelStep(ma, 4, 4, cea, 16'(rqa), rla);
    if (rst_n_b) mb = modelStep(mb, 3, 0, ceb, 16'(rqb), rlb);
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ce_a = 1'b0; req_a = '0; rel_a = 1'b0;
    ce_b = 1'b0; req_b = '0; rel_b = 1'b0;
    ma = modelReset(4);
    mb = modelReset(3);
    #2;
    checkOutput();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clk);
    #1;

    // All four requesting, release every second cycle: 0,1,2,3,0 with no gaps.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 3'b000, 1'b0);
    check("a_first_grant", 32'(grant_a), 32'd0);
    for (int i = 1; i < 9; i++)
      applyStimulus(1'b1, 4'b1111, (i % 2) == 1, 1'b0, 3'b000, 1'b0);
    check("a_wrap_grant", 32'(grant_a), 32'd0);

    // Lone requester 2: held for 4 cycles, then re-granted to itself.
    for (int i = 0; i < 11; i++)
      applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 3'b000, 1'b0);

    // Grant 1, then req 1011 skips index 2.
    applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b0, 3'b000, 1'b0);
    check("a_skip_to_3", 32'(grant_a), 32'd3);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b0, 3'b000, 1'b0);

    // Release with nobody waiting, then a single late requester.
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 3'b000, 1'b0);

    // Frozen while ce is low, even mid-tenure with release toggling.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 4'($urandom), (i % 2) == 0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 3'b000, 1'b0);

    // Three requesters, release every cycle, then reset in the middle of a tenure.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b1);
    #3;
    rst_n_b = 1'b0;
    mb = modelReset(3);
    #1;
    checkOutput();
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b1);
    rst_n_b = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 3'b111, 1'b0);
    check("b_first_after_reset", 32'(grant_b), 32'd0);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(3) != 0, 4'($urandom), $urandom_range(9) < 3,
                    $urandom_range(3) != 0, 3'($urandom), $urandom_range(9) < 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
